// File: rtl/rename_free_list_ctrl_pkg.sv
// Shared constants, types and FSM encoding for the rename free-list slice.
package rename_pkg;

   localparam int unsigned NUM_PHYS = 64;
   localparam int unsigned NUM_ARCH = 32;
   localparam int unsigned NUM_CP   = 4;
   localparam int unsigned FL_DEPTH = NUM_PHYS - NUM_ARCH;

   localparam int unsigned PREG_W   = $clog2(NUM_PHYS);
   localparam int unsigned CP_TAG_W = $clog2(NUM_CP);
   localparam int unsigned FL_PTR_W = $clog2(FL_DEPTH) + 1;

   typedef logic [PREG_W-1:0]   preg_t;
   typedef logic [CP_TAG_W-1:0] cp_tag_t;
   typedef logic [FL_PTR_W-1:0] fl_ptr_t;

   typedef enum logic {
      NORMAL  = 1'b0,
      RECOVER = 1'b1
   } fl_state_e;

endpackage

// File: rtl/rename_free_list_ctrl_cp_snapshot_queue.sv
// In-order circular queue of head snapshots with capture, commit of the
// oldest entry and restore-truncate to any valid entry.
module cp_snapshot_queue #(
   parameter int unsigned NUM_CP = 4,
   parameter int unsigned DATA_W = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      capture_en,
   input  logic [DATA_W-1:0]         capture_data,
   input  logic                      commit_req,
   input  logic                      restore_req,
   input  logic [$clog2(NUM_CP)-1:0] restore_tag,
   output logic                      full,
   output logic [$clog2(NUM_CP)-1:0] wr_tag,
   output logic                      restore_ok,
   output logic [DATA_W-1:0]         restore_data,
   output logic                      err_event
);

   localparam int unsigned TAG_W = $clog2(NUM_CP);
   typedef logic [TAG_W:0] qptr_t;

   qptr_t             rd_q, rd_d, wr_q, wr_d;
   logic [NUM_CP-1:0] valid_q, valid_d;
   logic [DATA_W-1:0] snap_q [NUM_CP];
   logic [DATA_W-1:0] snap_d [NUM_CP];

   logic             empty;
   logic             commit_ok;
   logic [TAG_W-1:0] rd_idx, wr_idx, keep_span, offs;

   // Occupancy flags and restore legality; a same-cycle commit of the
   // restore target retires it first, so that restore is illegal.
   always_comb begin
      rd_idx       = rd_q[TAG_W-1:0];
      wr_idx       = wr_q[TAG_W-1:0];
      empty        = (rd_q == wr_q);
      full         = (rd_idx == wr_idx) && (rd_q[TAG_W] != wr_q[TAG_W]);
      wr_tag       = wr_idx;
      commit_ok    = commit_req & ~empty;
      restore_ok   = restore_req & valid_q[restore_tag]
                     & ~(commit_ok & (restore_tag == rd_idx));
      restore_data = snap_q[restore_tag];
      err_event    = (commit_req & empty) | (restore_req & ~restore_ok);
   end

   // Next-state: commit retires the oldest slot, restore keeps rd..tag and
   // rewinds wr just past tag, capture appends at wr.
   always_comb begin
      rd_d      = rd_q;
      wr_d      = wr_q;
      valid_d   = valid_q;
      snap_d    = snap_q;
      offs      = '0;
      keep_span = restore_tag - rd_idx;
      if (commit_ok) begin
         valid_d[rd_idx] = 1'b0;
         rd_d            = rd_q + qptr_t'(1);
      end
      if (restore_ok) begin
         // Rebuild wr from rd so the wrap bit stays consistent with occupancy.
         wr_d = rd_q + qptr_t'(keep_span) + qptr_t'(1);
         for (int unsigned i = 0; i < NUM_CP; i++) begin
            offs = TAG_W'(i) - rd_idx;
            if (offs > keep_span) valid_d[i] = 1'b0;
         end
      end else if (capture_en) begin
         valid_d[wr_idx] = 1'b1;
         snap_d[wr_idx]  = capture_data;
         wr_d            = wr_q + qptr_t'(1);
      end
   end

   // Queue state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         valid_q <= '0;
         for (int unsigned i = 0; i < NUM_CP; i++) snap_q[i] <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         valid_q <= valid_d;
         snap_q  <= snap_d;
      end
   end

endmodule

// File: rtl/rename_free_list_ctrl.sv
// Physical-register free list: circular FIFO of free indices with one
// allocation and one release per cycle and single-cycle branch recovery.
module rename_free_list_ctrl
   import rename_pkg::*;
#(
   parameter int unsigned NUM_PHYS = rename_pkg::NUM_PHYS,
   parameter int unsigned NUM_ARCH = rename_pkg::NUM_ARCH,
   parameter int unsigned NUM_CP   = rename_pkg::NUM_CP
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        alloc_req,
   output logic                        alloc_gnt,
   output logic [$clog2(NUM_PHYS)-1:0] alloc_preg,
   input  logic                        rel_valid,
   input  logic [$clog2(NUM_PHYS)-1:0] rel_preg,
   input  logic                        cp_capture_req,
   output logic                        cp_capture_gnt,
   output logic [$clog2(NUM_CP)-1:0]   cp_capture_tag,
   input  logic                        cp_commit,
   input  logic                        cp_restore,
   input  logic [$clog2(NUM_CP)-1:0]   cp_restore_tag,
   output logic [$clog2(NUM_PHYS):0]   free_count,
   output logic                        busy,
   output logic                        err_overflow,
   output logic                        err_cp
);

   localparam int unsigned PW    = $clog2(NUM_PHYS);
   localparam int unsigned DEPTH = NUM_PHYS - NUM_ARCH;
   localparam int unsigned AW    = $clog2(DEPTH);
   typedef logic [AW:0] ptr_t;

   fl_state_e state_q, state_d;
   ptr_t      head_q, head_d, tail_q, tail_d;
   logic [PW-1:0] fifo_q [DEPTH];
   logic [PW-1:0] fifo_d [DEPTH];
   logic      err_overflow_q, err_overflow_d;
   logic      err_cp_q, err_cp_d;

   ptr_t                     occupancy;
   ptr_t                     cap_head;
   ptr_t                     cq_restore_head;
   logic                     normal, fl_empty, fl_full, rel_ok;
   logic                     cq_full, cq_restore_ok, cq_err;
   logic [$clog2(NUM_CP)-1:0] cq_wr_tag;

   // Grant decisions and status outputs, all combinational from current state.
   always_comb begin
      normal         = (state_q == NORMAL);
      occupancy      = tail_q - head_q;
      fl_empty       = (occupancy == '0);
      fl_full        = (occupancy == ptr_t'(DEPTH));
      alloc_gnt      = alloc_req & ~fl_empty & normal & ~cp_restore;
      alloc_preg     = fifo_q[head_q[AW-1:0]];
      cp_capture_gnt = cp_capture_req & ~cq_full & normal & ~cp_restore;
      cp_capture_tag = cq_wr_tag;
      cap_head       = head_q + ptr_t'(alloc_gnt);
      rel_ok         = rel_valid & (~fl_full | alloc_gnt);
      free_count     = (PW+1)'(occupancy);
      busy           = (state_q == RECOVER);
      err_overflow   = err_overflow_q;
      err_cp         = err_cp_q;
   end

   // Next-state: head advances on grant or rewinds on restore; tail is
   // independent of recovery so same-cycle releases always land.
   always_comb begin
      head_d = cap_head;
      if (cq_restore_ok) head_d = cq_restore_head;
      tail_d = tail_q;
      fifo_d = fifo_q;
      if (rel_ok) begin
         fifo_d[tail_q[AW-1:0]] = rel_preg;
         tail_d                 = tail_q + ptr_t'(1);
      end
      err_overflow_d = err_overflow_q | (rel_valid & ~rel_ok);
      err_cp_d       = err_cp_q | cq_err;
      state_d        = cq_restore_ok ? RECOVER : NORMAL;
   end

   // Free-list state registers; reset leaves the unmapped registers free.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= NORMAL;
         head_q         <= '0;
         tail_q         <= ptr_t'(DEPTH);
         err_overflow_q <= 1'b0;
         err_cp_q       <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= PW'(NUM_ARCH + i);
      end else begin
         state_q        <= state_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         err_overflow_q <= err_overflow_d;
         err_cp_q       <= err_cp_d;
         fifo_q         <= fifo_d;
      end
   end

   cp_snapshot_queue #(
      .NUM_CP (NUM_CP),
      .DATA_W (AW + 1)
   ) u_cp_queue (
      .clk          (clk),
      .rst          (rst),
      .capture_en   (cp_capture_gnt),
      .capture_data (cap_head),
      .commit_req   (cp_commit),
      .restore_req  (cp_restore),
      .restore_tag  (cp_restore_tag),
      .full         (cq_full),
      .wr_tag       (cq_wr_tag),
      .restore_ok   (cq_restore_ok),
      .restore_data (cq_restore_head),
      .err_event    (cq_err)
   );

endmodule

// File: tb/tb_rename_free_list_ctrl.sv
// Scoreboard bench for rename_free_list_ctrl: a reference free-list model
// predicts each cycle's outputs; expected allocation indices are queued when
// the request is driven and popped when the grant is observed.
module tb_rename_free_list_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       alloc_req = 1'b0;
   logic       alloc_gnt;
   logic [5:0] alloc_preg;
   logic       rel_valid = 1'b0;
   logic [5:0] rel_preg = '0;
   logic       cp_capture_req = 1'b0;
   logic       cp_capture_gnt;
   logic [1:0] cp_capture_tag;
   logic       cp_commit = 1'b0;
   logic       cp_restore = 1'b0;
   logic [1:0] cp_restore_tag = '0;
   logic [6:0] free_count;
   logic       busy;
   logic       err_overflow;
   logic       err_cp;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [5:0] m_head, m_tail;
   int         m_fifo [32];
   logic [5:0] m_snap [4];
   int         m_rd, m_cnt;
   bit         m_recover, m_eovf, m_ecp;
   int         exp_q [$];

   rename_free_list_ctrl #(
      .NUM_PHYS (64),
      .NUM_ARCH (32),
      .NUM_CP   (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .alloc_req      (alloc_req),
      .alloc_gnt      (alloc_gnt),
      .alloc_preg     (alloc_preg),
      .rel_valid      (rel_valid),
      .rel_preg       (rel_preg),
      .cp_capture_req (cp_capture_req),
      .cp_capture_gnt (cp_capture_gnt),
      .cp_capture_tag (cp_capture_tag),
      .cp_commit      (cp_commit),
      .cp_restore     (cp_restore),
      .cp_restore_tag (cp_restore_tag),
      .free_count     (free_count),
      .busy           (busy),
      .err_overflow   (err_overflow),
      .err_cp         (err_cp)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_head = '0;
      m_tail = 6'd32;
      for (int i = 0; i < 32; i++) m_fifo[i] = 32 + i;
      for (int i = 0; i < 4; i++) m_snap[i] = '0;
      m_rd      = 0;
      m_cnt     = 0;
      m_recover = 0;
      m_eovf    = 0;
      m_ecp     = 0;
      exp_q.delete();
   endtask

   // Reset is asserted with live requests on the inputs to show it dominates.
   task automatic do_reset();
      rst            = 1'b1;
      alloc_req      = 1'b1;
      rel_valid      = 1'b1;
      rel_preg       = 6'd9;
      cp_capture_req = 1'b1;
      cp_commit      = 1'b1;
      cp_restore     = 1'b0;
      @(posedge clk);
      #1;
      rst            = 1'b0;
      alloc_req      = 1'b0;
      rel_valid      = 1'b0;
      cp_capture_req = 1'b0;
      cp_commit      = 1'b0;
      model_reset();
   endtask

   task automatic step(input bit a, input bit rv, input int rp, input bit cap,
                       input bit cm, input bit rs, input int rt);
      logic [5:0] free;
      logic [5:0] snap_val;
      bit eg, ec, cok, rok;
      int wr, rd2, cnt2, e;
      free = m_tail - m_head;
      eg   = a && (free != 0) && !m_recover && !rs;
      ec   = cap && (m_cnt < 4) && !m_recover && !rs;
      wr   = (m_rd + m_cnt) % 4;
      if (eg) exp_q.push_back(m_fifo[m_head[4:0]]);

      alloc_req      = a;
      rel_valid      = rv;
      rel_preg       = 6'(rp);
      cp_capture_req = cap;
      cp_commit      = cm;
      cp_restore     = rs;
      cp_restore_tag = 2'(rt);

      @(negedge clk);
      check_val("alloc_gnt", 32'(alloc_gnt), 32'(eg));
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_val("alloc_preg", 32'(alloc_preg), e);
      end
      check_val("cp_capture_gnt", 32'(cp_capture_gnt), 32'(ec));
      if (ec) check_val("cp_capture_tag", 32'(cp_capture_tag), wr);
      check_val("free_count", 32'(free_count), 32'(free));
      check_val("busy", 32'(busy), 32'(m_recover));
      check_val("err_overflow", 32'(err_overflow), 32'(m_eovf));
      check_val("err_cp", 32'(err_cp), 32'(m_ecp));

      cok = cm && (m_cnt > 0);
      if (cm && m_cnt == 0) m_ecp = 1;
      rd2  = m_rd;
      cnt2 = m_cnt;
      if (cok) begin
         rd2  = (m_rd + 1) % 4;
         cnt2 = m_cnt - 1;
      end
      rok = rs && (((rt - rd2) & 3) < cnt2);
      if (rs && !rok) m_ecp = 1;
      snap_val = m_head + 6'(eg);
      if (ec) begin
         m_snap[wr] = snap_val;
         cnt2++;
      end
      if (rok) begin
         m_head = m_snap[rt];
         cnt2   = ((rt - rd2) & 3) + 1;
      end else begin
         m_head = snap_val;
      end
      m_rd  = rd2;
      m_cnt = cnt2;
      if (rv) begin
         if (free != 6'd32 || eg) begin
            m_fifo[m_tail[4:0]] = rp;
            m_tail = m_tail + 6'd1;
         end else begin
            m_eovf = 1;
         end
      end
      m_recover = rok;

      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      #1;

      // Drain the full list, then one more request at empty
      do_reset();
      idle();
      repeat (32) step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);

      // Release into empty list, reallocate; alloc+release at free_count 1
      step(0, 1, 5, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 7, 0, 0, 0, 0);
      step(1, 1, 9, 0, 0, 0, 0);
      idle();
      step(1, 0, 0, 0, 0, 0, 0);

      // Checkpoint with same-cycle alloc, then mispredict back to it
      do_reset();
      repeat (3) step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0);
      repeat (2) step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      idle();

      // Checkpoint queue full, wrap, restore-truncate, invalid restore
      do_reset();
      repeat (4) step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 2);
      idle();
      step(0, 0, 0, 0, 0, 1, 3);
      idle();
      step(0, 0, 0, 1, 0, 0, 0);

      // Restore colliding with alloc, capture and release
      do_reset();
      repeat (2) step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 3, 1, 0, 1, 0);
      idle();
      step(1, 0, 0, 0, 0, 0, 0);
      idle();

      // Overflow, empty commit, same-slot commit+restore, mid-run reset
      do_reset();
      step(0, 1, 12, 0, 0, 0, 0);
      idle();
      step(1, 1, 20, 0, 0, 0, 0);
      idle();
      do_reset();
      step(0, 0, 0, 0, 1, 0, 0);
      idle();
      do_reset();
      step(1, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1, 0);
      idle();
      step(1, 1, 40, 1, 0, 0, 0);
      do_reset();
      idle();

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              int'($urandom_range(0, 63)), $urandom_range(0, 4) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
              int'($urandom_range(0, 3)));
         if (n == 200) do_reset();
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
